// File: rtl/clock_monitor_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel clock monitor.
// Parameter legality functions are evaluated by the top during elaboration.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edgeKind_t;

  function automatic longint unsigned satMax(int unsigned width);
    return (longint'(1) << width) - 1;
  endfunction

  function automatic bit timeoutLegal(int unsigned width, longint unsigned timeout);
    return timeout <= satMax(width);
  endfunction

  function automatic bit syncLegal(int unsigned stages);
    return stages >= 2;
  endfunction

endpackage

// File: rtl/clock_monitor_if.sv
// Bundle of monitored clocks and per-channel measurement results.
// The slave side is the monitor itself; the master side is whatever drives and reads it.
interface clock_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);

  logic [NUM_CH-1:0]       clk_in;
  logic [NUM_CH*CNT_W-1:0] ht_out;
  logic [NUM_CH*CNT_W-1:0] lt_out;
  logic [NUM_CH-1:0]       ht_valid;
  logic [NUM_CH-1:0]       lt_valid;
  logic [NUM_CH-1:0]       upd;
  logic [NUM_CH-1:0]       stopped;

  modport master (
    output clk_in,
    input  ht_out, lt_out, ht_valid, lt_valid, upd, stopped
  );

  modport slave (
    input  clk_in,
    output ht_out, lt_out, ht_valid, lt_valid, upd, stopped
  );

endinterface

// File: rtl/clock_monitor_ch.sv
// One monitored clock: synchroniser, edge detect, saturating phase counter,
// arm/stop bookkeeping and registered high/low phase results.
module clock_monitor_ch
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32'(satMax(CNT_W))
) (
  input  logic             clk_fst,
  input  logic             reset_n,
  input  logic             clk_i,
  output logic [CNT_W-1:0] ht_o,
  output logic [CNT_W-1:0] lt_o,
  output logic             htValid_o,
  output logic             ltValid_o,
  output logic             upd_o,
  output logic             stopped_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(satMax(CNT_W));
  localparam logic [CNT_W:0]   TMO     = (CNT_W+1)'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prevLevel_q, prevLevel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic                   stopped_q, stopped_d;
  logic [CNT_W-1:0]       ht_q, ht_d;
  logic [CNT_W-1:0]       lt_q, lt_d;
  logic                   htValid_q, htValid_d;
  logic                   ltValid_q, ltValid_d;
  logic                   upd_q, upd_d;

  logic                   level;
  edgeKind_t              edgeKind;
  logic [CNT_W:0]         cntInc;
  logic [CNT_W-1:0]       phaseLen;
  logic                   stopHit;

  assign level    = sync_q[SYNC_STAGES-1];
  assign cntInc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign phaseLen = (cnt_q == CNT_MAX) ? CNT_MAX : cntInc[CNT_W-1:0];

  always_comb begin
    edgeKind = EDGE_NONE;
    if (level && !prevLevel_q) begin
      edgeKind = EDGE_RISE;
    end else if (!level && prevLevel_q) begin
      edgeKind = EDGE_FALL;
    end
  end

  // An edge in the same cycle as the timeout wins, so stopHit requires EDGE_NONE.
  assign stopHit = (TMO != '0) && (edgeKind == EDGE_NONE) && (cntInc == TMO);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_i};
    prevLevel_d = level;
    cnt_d       = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    armed_d     = armed_q;
    stopped_d   = stopped_q;
    ht_d        = ht_q;
    lt_d        = lt_q;
    htValid_d   = htValid_q;
    ltValid_d   = ltValid_q;
    upd_d       = 1'b0;

    unique case (edgeKind)
      EDGE_RISE, EDGE_FALL: begin
        cnt_d     = '0;
        armed_d   = 1'b1;
        stopped_d = 1'b0;
        // The first edge after reset or stop ends a partial phase and only arms.
        if (armed_q) begin
          upd_d = 1'b1;
          if (edgeKind == EDGE_RISE) begin
            lt_d      = phaseLen;
            ltValid_d = 1'b1;
          end else begin
            ht_d      = phaseLen;
            htValid_d = 1'b1;
          end
        end
      end
      default: begin
        if (stopHit) begin
          stopped_d = 1'b1;
          armed_d   = 1'b0;
          htValid_d = 1'b0;
          ltValid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_fst) begin
    if (!reset_n) begin
      sync_q      <= '0;
      prevLevel_q <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      stopped_q   <= 1'b0;
      ht_q        <= '0;
      lt_q        <= '0;
      htValid_q   <= 1'b0;
      ltValid_q   <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prevLevel_q <= prevLevel_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      stopped_q   <= stopped_d;
      ht_q        <= ht_d;
      lt_q        <= lt_d;
      htValid_q   <= htValid_d;
      ltValid_q   <= ltValid_d;
      upd_q       <= upd_d;
    end
  end

  assign ht_o      = ht_q;
  assign lt_o      = lt_q;
  assign htValid_o = htValid_q;
  assign ltValid_o = ltValid_q;
  assign upd_o     = upd_q;
  assign stopped_o = stopped_q;

endmodule

// File: rtl/clock_monitor.sv
// Multi-channel clock high/low-time monitor: one independent clock_monitor_ch
// per monitored clock, results packed channel i at [i*CNT_W +: CNT_W].
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32'(satMax(CNT_W))
) (
  input  logic           clk_fst,
  input  logic           reset_n,
  clock_monitor_if.slave mon
);

  if (!syncLegal(SYNC_STAGES)) begin : gBadSync
    $error("clock_monitor: SYNC_STAGES must be at least 2");
  end

  if (!timeoutLegal(CNT_W, TIMEOUT)) begin : gBadTimeout
    $error("clock_monitor: TIMEOUT must not exceed 2**CNT_W-1");
  end

  wire [NUM_CH*CNT_W-1:0] htBus;
  wire [NUM_CH*CNT_W-1:0] ltBus;
  wire [NUM_CH-1:0]       htValidBus;
  wire [NUM_CH-1:0]       ltValidBus;
  wire [NUM_CH-1:0]       updBus;
  wire [NUM_CH-1:0]       stoppedBus;

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    clock_monitor_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) uCh (
      .clk_fst   (clk_fst),
      .reset_n   (reset_n),
      .clk_i     (mon.clk_in[i]),
      .ht_o      (htBus[i*CNT_W +: CNT_W]),
      .lt_o      (ltBus[i*CNT_W +: CNT_W]),
      .htValid_o (htValidBus[i]),
      .ltValid_o (ltValidBus[i]),
      .upd_o     (updBus[i]),
      .stopped_o (stoppedBus[i])
    );
  end

  assign mon.ht_out   = htBus;
  assign mon.lt_out   = ltBus;
  assign mon.ht_valid = htValidBus;
  assign mon.lt_valid = ltValidBus;
  assign mon.upd      = updBus;
  assign mon.stopped  = stoppedBus;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (16-bit/TIMEOUT=16 with 2 channels, 4-bit/no timeout
// with 1 channel) checked every cycle against an edge-index reference model plus scenario constants.
module tb_clock_monitor;

  localparam int S    = 2;
  localparam int NCH  = 3;
  localparam int HIST = 8192;

  logic clk_fst = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_fst = ~clk_fst;

  clock_monitor_if #(.NUM_CH(2), .CNT_W(16)) ifA ();
  clock_monitor_if #(.NUM_CH(1), .CNT_W(4))  ifB ();

  clock_monitor #(.NUM_CH(2), .CNT_W(16), .SYNC_STAGES(S), .TIMEOUT(16)) dutA (
    .clk_fst (clk_fst),
    .reset_n (reset_n),
    .mon     (ifA)
  );

  clock_monitor #(.NUM_CH(1), .CNT_W(4), .SYNC_STAGES(S), .TIMEOUT(0)) dutB (
    .clk_fst (clk_fst),
    .reset_n (reset_n),
    .mon     (ifB)
  );

  int tests  = 0;
  int failed = 0;

  // Model channels 0,1 map to dutA, channel 2 to dutB.
  int chMax[NCH] = '{65535, 65535, 15};
  int chTmo[NCH] = '{16, 16, 0};

  logic [NCH-1:0] hist [HIST];
  int edgeN     = 0;
  int lastReset = 0;
  int mLastZero[NCH];
  bit mArmed[NCH];
  bit mStp[NCH];
  bit mHtV[NCH];
  bit mLtV[NCH];
  bit mUpd[NCH];
  int mHt[NCH];
  int mLt[NCH];

  function automatic bit sampleAt(int t, int c);
    if (t <= lastReset || t < 0) return 1'b0;
    return hist[t][c];
  endfunction

  // Reference: a phase ends at the edge index where the delayed input sample changes;
  // its length is the distance in edges since the previous change (or reset).
  always @(posedge clk_fst) begin
    bit cur, prv;
    int len;
    edgeN++;
    if (!reset_n) begin
      lastReset    = edgeN;
      hist[edgeN]  = '0;
      for (int c = 0; c < NCH; c++) begin
        mLastZero[c] = edgeN;
        mArmed[c] = 0; mStp[c] = 0; mHtV[c] = 0; mLtV[c] = 0; mUpd[c] = 0;
        mHt[c] = 0; mLt[c] = 0;
      end
    end else begin
      hist[edgeN] = {ifB.clk_in[0], ifA.clk_in};
      for (int c = 0; c < NCH; c++) begin
        cur = sampleAt(edgeN - S, c);
        prv = sampleAt(edgeN - S - 1, c);
        mUpd[c] = 0;
        if (cur != prv) begin
          len = edgeN - mLastZero[c];
          if (len > chMax[c]) len = chMax[c];
          if (mArmed[c]) begin
            if (cur) begin mLt[c] = len; mLtV[c] = 1; end
            else     begin mHt[c] = len; mHtV[c] = 1; end
            mUpd[c] = 1;
          end
          mArmed[c] = 1;
          mStp[c] = 0;
          mLastZero[c] = edgeN;
        end else if (chTmo[c] != 0 && edgeN - mLastZero[c] == chTmo[c]) begin
          mStp[c] = 1; mArmed[c] = 0; mHtV[c] = 0; mLtV[c] = 0;
        end
      end
    end
  end

  function automatic logic [35:0] obsCh(int c);
    if (c < 2)
      return {ifA.ht_out[c*16 +: 16], ifA.lt_out[c*16 +: 16],
              ifA.ht_valid[c], ifA.lt_valid[c], ifA.upd[c], ifA.stopped[c]};
    return {12'd0, ifB.ht_out, 12'd0, ifB.lt_out,
            ifB.ht_valid[0], ifB.lt_valid[0], ifB.upd[0], ifB.stopped[0]};
  endfunction

  function automatic logic [35:0] expCh(int c);
    return {16'(mHt[c]), 16'(mLt[c]), mHtV[c], mLtV[c], mUpd[c], mStp[c]};
  endfunction

  function automatic logic [83:0] allOuts();
    return {ifA.ht_out, ifA.lt_out, ifA.ht_valid, ifA.lt_valid, ifA.upd, ifA.stopped,
            ifB.ht_out, ifB.lt_out, ifB.ht_valid, ifB.lt_valid, ifB.upd, ifB.stopped};
  endfunction

  // Square-wave generators, stepped once per clk_fst cycle on the falling edge.
  int genHi[NCH];
  int genLo[NCH];
  int genRem[NCH];
  bit genLvl[NCH];

  task automatic setWave(int c, int hi, int lo);
    genHi[c]  = hi;
    genLo[c]  = lo;
    genRem[c] = genLvl[c] ? hi : lo;
  endtask

  task automatic setHold(int c);
    genHi[c] = 0;
    genLo[c] = 0;
  endtask

  task automatic stepInputs();
    for (int c = 0; c < NCH; c++) begin
      if (genHi[c] != 0) begin
        genRem[c]--;
        if (genRem[c] <= 0) begin
          genLvl[c] = !genLvl[c];
          genRem[c] = genLvl[c] ? genHi[c] : genLo[c];
        end
      end
    end
    ifA.clk_in = {genLvl[1], genLvl[0]};
    ifB.clk_in = genLvl[2];
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk_fst);
      tests++;
      if (allOuts() !== '0) begin
        failed++;
        $display("[TB] FAIL reset_outputs got=%h exp=0", allOuts());
      end
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL reset_model ch%0d got=%h exp=%h", c, obsCh(c), expCh(c));
        end
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int firstUpd = -1;
    int nUpd = 0;
    setWave(0, 4, 4);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL basic ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      if (ifA.upd[0]) begin
        nUpd++;
        if (firstUpd < 0) firstUpd = i;
      end
      stepInputs();
    end
    tests++;
    if (firstUpd != 11) begin
      failed++;
      $display("[TB] FAIL basic_first_upd got=%0d exp=11", firstUpd);
    end
    tests++;
    if (nUpd != 8) begin
      failed++;
      $display("[TB] FAIL basic_upd_count got=%0d exp=8", nUpd);
    end
    tests++;
    if ({ifA.ht_out[15:0], ifA.lt_out[15:0], ifA.ht_valid[0], ifA.lt_valid[0]} !== {16'd4, 16'd4, 2'b11}) begin
      failed++;
      $display("[TB] FAIL basic_values got ht=%0d lt=%0d v=%b%b exp ht=4 lt=4 v=11",
               ifA.ht_out[15:0], ifA.lt_out[15:0], ifA.ht_valid[0], ifA.lt_valid[0]);
    end
  endtask

  task automatic test_dual();
    setWave(0, 3, 5);
    setWave(1, 1, 1);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL dual ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      stepInputs();
    end
    tests++;
    if ({ifA.ht_out, ifA.lt_out, ifA.ht_valid, ifA.lt_valid} !== {16'd1, 16'd3, 16'd1, 16'd5, 2'b11, 2'b11}) begin
      failed++;
      $display("[TB] FAIL dual_values got ht=%h lt=%h exp ht=00010003 lt=00010005", ifA.ht_out, ifA.lt_out);
    end
  endtask

  task automatic test_saturate();
    setWave(2, 3, 20);
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL saturate ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      stepInputs();
    end
    tests++;
    if ({ifB.lt_out, ifB.lt_valid[0], ifB.ht_out} !== {4'd15, 1'b1, 4'd3}) begin
      failed++;
      $display("[TB] FAIL saturate_values got lt=%0d ltv=%b ht=%0d exp lt=15 ltv=1 ht=3",
               ifB.lt_out, ifB.lt_valid[0], ifB.ht_out);
    end
  endtask

  task automatic test_stop();
    int lastUpd = -1;
    int stopAt = -1;
    int clearAt = -1;
    int firstWrite = -1;
    bit held = 0;
    setWave(0, 4, 4);
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL stop ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      if (ifA.upd[0]) lastUpd = i;
      if (ifA.stopped[0] && stopAt < 0) stopAt = i;
      if (!held && i >= 24 && genLvl[0]) begin
        setHold(0);
        held = 1;
      end
      stepInputs();
    end
    tests++;
    if (stopAt < 0 || stopAt - lastUpd != 16) begin
      failed++;
      $display("[TB] FAIL stop_delay got=%0d exp=16", stopAt - lastUpd);
    end
    tests++;
    if ({ifA.stopped[0], ifA.ht_valid[0], ifA.lt_valid[0], ifA.ht_out[15:0], ifA.lt_out[15:0]} !==
        {3'b100, 16'd4, 16'd4}) begin
      failed++;
      $display("[TB] FAIL stop_state got stp=%b v=%b%b ht=%0d lt=%0d exp stp=1 v=00 ht=4 lt=4",
               ifA.stopped[0], ifA.ht_valid[0], ifA.lt_valid[0], ifA.ht_out[15:0], ifA.lt_out[15:0]);
    end
    setWave(0, 4, 4);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL restart ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      if (firstWrite < 0 && clearAt >= 0 && ifA.upd[0]) begin
        firstWrite = i;
        tests++;
        if ({ifA.lt_out[15:0], ifA.lt_valid[0], ifA.ht_valid[0]} !== {16'd4, 2'b10}) begin
          failed++;
          $display("[TB] FAIL restart_write got lt=%0d v=%b%b exp lt=4 v=10",
                   ifA.lt_out[15:0], ifA.lt_valid[0], ifA.ht_valid[0]);
        end
      end
      if (clearAt < 0 && !ifA.stopped[0]) begin
        clearAt = i;
        tests++;
        if (ifA.upd[0] !== 1'b0) begin
          failed++;
          $display("[TB] FAIL restart_arm_upd got=%b exp=0", ifA.upd[0]);
        end
      end
      stepInputs();
    end
    tests++;
    if (clearAt < 0 || firstWrite < 0) begin
      failed++;
      $display("[TB] FAIL restart_timeout got clear=%0d write=%0d exp both seen", clearAt, firstWrite);
    end
  endtask

  task automatic test_same_cycle();
    bit sawStop = 0;
    setWave(0, 16, 16);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL same_cycle ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      if (i >= 40 && ifA.stopped[0]) sawStop = 1;
      stepInputs();
    end
    tests++;
    if ({sawStop, ifA.ht_out[15:0], ifA.lt_out[15:0], ifA.ht_valid[0], ifA.lt_valid[0]} !==
        {1'b0, 16'd16, 16'd16, 2'b11}) begin
      failed++;
      $display("[TB] FAIL same_cycle_values got stp=%b ht=%0d lt=%0d exp stp=0 ht=16 lt=16",
               sawStop, ifA.ht_out[15:0], ifA.lt_out[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    setWave(0, 4, 4);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL reset_mid_pre ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      stepInputs();
    end
    tests++;
    if ({ifA.ht_out[15:0], ifA.ht_valid[0]} !== {16'd4, 1'b1}) begin
      failed++;
      $display("[TB] FAIL reset_mid_before got ht=%0d v=%b exp ht=4 v=1", ifA.ht_out[15:0], ifA.ht_valid[0]);
    end
    reset_n = 1'b0;
    @(negedge clk_fst);
    tests++;
    if (allOuts() !== '0) begin
      failed++;
      $display("[TB] FAIL reset_mid_zero got=%h exp=0", allOuts());
    end
    reset_n = 1'b1;
    stepInputs();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_fst);
      for (int c = 0; c < NCH; c++) begin
        tests++;
        if (obsCh(c) !== expCh(c)) begin
          failed++;
          $display("[TB] FAIL reset_mid_post ch%0d cyc%0d got=%h exp=%h", c, i, obsCh(c), expCh(c));
        end
      end
      stepInputs();
    end
    tests++;
    if ({ifA.ht_out[15:0], ifA.lt_out[15:0], ifA.ht_valid[0], ifA.lt_valid[0]} !== {16'd4, 16'd4, 2'b11}) begin
      failed++;
      $display("[TB] FAIL reset_mid_after got ht=%0d lt=%0d exp ht=4 lt=4", ifA.ht_out[15:0], ifA.lt_out[15:0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) begin
        setWave(c, int'($urandom_range(12, 1)), int'($urandom_range((c == 2) ? 24 : 12, 1)));
      end
      if (r % 3 == 2) setHold(int'($urandom_range(2, 0)));
      for (int i = 1; i <= 150; i++) begin
        @(negedge clk_fst);
        for (int c = 0; c < NCH; c++) begin
          tests++;
          if (obsCh(c) !== expCh(c)) begin
            failed++;
            $display("[TB] FAIL random r%0d ch%0d cyc%0d got=%h exp=%h", r, c, i, obsCh(c), expCh(c));
          end
        end
        stepInputs();
      end
    end
  endtask

  initial begin
    ifA.clk_in = '0;
    ifB.clk_in = '0;
    for (int c = 0; c < NCH; c++) begin
      genHi[c] = 0; genLo[c] = 0; genRem[c] = 0; genLvl[c] = 0;
    end
    test_reset();
    test_basic();
    test_dual();
    test_saturate();
    test_stop();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
